// File: rtl/rx_packet_ctrl.sv
// Receive control around the bit timer: start detection, 9-bit shift-in,
// stop-bit framing check and a one-entry output buffer with read handshake.
module rx_packet_ctrl (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       serial_in,
    input  logic       shift_strobe,
    input  logic       packet_done,
    input  logic       data_read,
    output logic       enable_timer,
    output logic [7:0] rx_data,
    output logic       data_ready,
    output logic       overrun_error,
    output logic       framing_error
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        RECEIVE,
        STOP_CHK,
        STORE
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic       sync1_reg;
    logic       synced_reg;
    logic       prev_reg;
    logic [8:0] sr_reg;
    logic       start_edge;
    logic       load;

    // Line idles high, so every stage resets to 1 to avoid a false start.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_reg  <= 1'b1;
            synced_reg <= 1'b1;
            prev_reg   <= 1'b1;
        end else begin
            sync1_reg  <= serial_in;
            synced_reg <= sync1_reg;
            prev_reg   <= synced_reg;
        end
    end

    assign start_edge = prev_reg & ~synced_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        enable_timer = 1'b0;
        load         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_edge) begin
                    state_next = START;
                end
            end
            START: begin
                state_next = RECEIVE;
            end
            RECEIVE: begin
                enable_timer = 1'b1;
                if (packet_done) begin
                    state_next = STOP_CHK;
                end
            end
            STOP_CHK: begin
                state_next = sr_reg[8] ? STORE : IDLE;
            end
            STORE: begin
                load       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // LSB arrives first, so bits enter at the top and walk down to sr[0].
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sr_reg <= 9'h1FF;
        end else if (state_reg == START) begin
            sr_reg <= 9'h1FF;
        end else if (state_reg == RECEIVE && shift_strobe) begin
            sr_reg <= {synced_reg, sr_reg[8:1]};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            framing_error <= 1'b0;
        end else if (state_reg == START) begin
            framing_error <= 1'b0;
        end else if (state_reg == STOP_CHK) begin
            framing_error <= ~sr_reg[8];
        end
    end

    // A load takes priority over a simultaneous read so the fresh byte stays flagged.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_data       <= 8'hFF;
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
        end else if (load) begin
            rx_data    <= sr_reg[7:0];
            data_ready <= 1'b1;
            if (data_ready && !data_read) begin
                overrun_error <= 1'b1;
            end
        end else if (data_read) begin
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// Directed bench for rx_packet_ctrl: stimulus pushes expected output tuples
// {framing_error, overrun_error, data_ready, rx_data}; a monitor pops on change.
module tb_rx_packet_ctrl;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       serial_in = 1'b1;
    logic       shift_strobe = 1'b0;
    logic       packet_done = 1'b0;
    logic       data_read = 1'b0;
    logic       enable_timer;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       overrun_error;
    logic       framing_error;

    int checks = 0;
    int errors = 0;

    logic [10:0] exp_q[$];
    logic        mon_en = 1'b0;
    logic [10:0] prev_t;

    logic       m_fe = 1'b0;
    logic       m_ovr = 1'b0;
    logic       m_ready = 1'b0;
    logic [7:0] m_data = 8'hFF;

    rx_packet_ctrl dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .serial_in    (serial_in),
        .shift_strobe (shift_strobe),
        .packet_done  (packet_done),
        .data_read    (data_read),
        .enable_timer (enable_timer),
        .rx_data      (rx_data),
        .data_ready   (data_ready),
        .overrun_error(overrun_error),
        .framing_error(framing_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [10:0] mtuple();
        return {m_fe, m_ovr, m_ready, m_data};
    endfunction

    // Monitor: every change of the output tuple must match the next expectation.
    always @(negedge clk) begin
        logic [10:0] cur;
        logic [10:0] e;
        if (mon_en) begin
            cur = {framing_error, overrun_error, data_ready, rx_data};
            if (cur !== prev_t) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_change actual=%h required=%h", cur, prev_t);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn fe=%b ovr=%b rdy=%b data=%h", cur[10], cur[9], cur[8], cur[7:0]);
                    chk("scoreboard", {21'd0, cur}, {21'd0, e});
                end
                prev_t = cur;
            end
        end
    end

    task automatic send_frame(input logic [7:0] data, input bit stop, input bit together,
                              input bit collide);
        int n;
        logic       old_ready;
        logic [7:0] old_data;
        bit         b;
        old_ready = m_ready;
        old_data  = m_data;
        if (m_fe) begin
            m_fe = 1'b0;
            exp_q.push_back(mtuple());
        end
        if (stop) begin
            m_ovr   = m_ovr | (m_ready & ~collide);
            m_ready = 1'b1;
            m_data  = data;
        end else begin
            m_fe = 1'b1;
        end
        exp_q.push_back(mtuple());

        @(negedge clk);
        serial_in = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!enable_timer && n < 12);
        chk("start_latency", n, 4);

        for (int i = 0; i < 9; i++) begin
            b = (i < 8) ? data[i] : stop;
            serial_in = b;
            repeat (8) @(negedge clk);
            chk("enable_during_rx", enable_timer, 1);
            @(negedge clk);
            shift_strobe = 1'b1;
            packet_done  = (i == 8) && together;
            @(negedge clk);
            shift_strobe = 1'b0;
            packet_done  = 1'b0;
        end
        if (!together) begin
            @(negedge clk);
            packet_done = 1'b1;
            @(negedge clk);
            packet_done = 1'b0;
        end
        chk("enable_off_n1", enable_timer, 0);
        @(negedge clk);
        chk("framing_n2", framing_error, !stop);
        chk("buffer_hold_n2", {data_ready, rx_data}, {old_ready, old_data});
        data_read = collide;
        @(negedge clk);
        data_read = 1'b0;
        chk("rx_data_n3", rx_data, stop ? data : old_data);
        chk("data_ready_n3", data_ready, stop ? 1'b1 : old_ready);
        serial_in = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic read_pulse();
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        exp_q.push_back(mtuple());
        @(negedge clk);
        data_read = 1'b1;
        @(negedge clk);
        data_read = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        #2 n_rst = 1'b0;
        #1;
        chk("rst_enable", enable_timer, 0);
        chk("rst_rx_data", rx_data, 8'hFF);
        chk("rst_ready", data_ready, 0);
        chk("rst_overrun", overrun_error, 0);
        chk("rst_framing", framing_error, 0);
        repeat (2) @(negedge clk);
        n_rst  = 1'b1;
        prev_t = 11'h0FF;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);

        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        read_pulse();
        send_frame(8'h11, 1'b1, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        chk("overrun_set", overrun_error, 1);
        read_pulse();
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        send_frame(8'h7E, 1'b1, 1'b0, 1'b1);
        chk("collision_overrun", overrun_error, 0);

        // Stray packet_done while idle must not start or load anything.
        @(negedge clk);
        packet_done = 1'b1;
        @(negedge clk);
        packet_done = 1'b0;
        repeat (6) @(negedge clk);
        chk("stray_done_enable", enable_timer, 0);

        // Reset in the middle of a frame.
        m_fe = 1'b0; m_ovr = 1'b0; m_ready = 1'b0; m_data = 8'hFF;
        exp_q.push_back(mtuple());
        @(negedge clk);
        serial_in = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!enable_timer && n < 12);
        chk("midrst_start", enable_timer, 1);
        serial_in = 1'b1;
        repeat (8) @(negedge clk);
        shift_strobe = 1'b1;
        @(negedge clk);
        shift_strobe = 1'b0;
        repeat (3) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        chk("midrst_enable", enable_timer, 0);
        chk("midrst_rx_data", rx_data, 8'hFF);
        chk("midrst_ready", data_ready, 0);
        chk("midrst_overrun", overrun_error, 0);
        chk("midrst_framing", framing_error, 0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (4) @(negedge clk);

        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        read_pulse();
        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_packet_ctrl.md
# rx_packet_ctrl

Receive-side control stage for the serial receiver. Sits directly around the bit timer: it detects the start bit, asserts `enable_timer`, and consumes the timer's `shift_strobe` and `packet_done` pulses. It shifts in 8 data bits plus a stop bit, checks framing, and hands completed bytes to the consumer through a one-entry buffer with ready/read handshake and error flags.

## Interface
Parameters:
- none; widths are fixed at 8 data bits, 1 stop bit, LSB first.

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `n_rst`  in  1  reset, asynchronous, active-low
- `serial_in`  in  1  raw asynchronous serial line, idle high
- `shift_strobe`  in  1  one-cycle bit-sample pulse from the bit timer
- `packet_done`  in  1  one-cycle pulse from the bit timer after the 9th strobe
- `data_read`  in  1  consumer acknowledge; level, sampled each cycle
- `enable_timer`  out  1  runs the bit timer
- `rx_data`  out  8  last accepted byte
- `data_ready`  out  1  `rx_data` holds an unread byte
- `overrun_error`  out  1  a new byte overwrote an unread byte
- `framing_error`  out  1  last frame had stop bit = 0

## Operation
- **Synchronizer:** 2-flop synchronizer on `serial_in`, both flops reset to 1. A third flop holds the previous synced value, reset to 1.
- **Start detect:** `start_edge` = prev==1 && synced==0. It is combinational from registered values and lasts 1 cycle.
- **Shift register:** 9 bits, reset 9'h1FF. It updates only in RECEIVE when `shift_strobe`=1: sr <= {synced, sr[8:1]}. After 9 shifts, sr[7:0] is the data (sr[0] is the first received bit) and sr[8] is the stop bit.
- **FSM states:**
  - IDLE: `enable_timer`=0. Goes to START on `start_edge`.
  - START: single cycle. Clears `framing_error` and presets sr to 9'h1FF. Goes to RECEIVE.
  - RECEIVE: `enable_timer`=1. Goes to STOP_CHK when `packet_done`=1.
  - STOP_CHK: single cycle, `enable_timer`=0. Registers `framing_error` <= ~sr[8]. Goes to STORE if sr[8]=1, else to IDLE.
  - STORE: single cycle. Asserts internal `load`. Goes to IDLE.
- **Ignored inputs:** `start_edge` outside IDLE, and `packet_done` outside RECEIVE.
- **Strobe and done together:** if `shift_strobe` and `packet_done` are both high in the same RECEIVE cycle, the shift happens and the state still advances to STOP_CHK.
- **Output buffer on `load`:** `rx_data` <= sr[7:0] and `data_ready` <= 1.
- **Overrun:** `overrun_error` <= 1 if `load` occurs while `data_ready`=1 and `data_read`=0.
- **`data_read`=1 without `load`:** clears `data_ready` and `overrun_error`.
- **`load` and `data_read` in the same cycle:** `load` wins. `data_ready` stays 1 and `overrun_error` is not set.
- **`framing_error` hold:** held until the next START. A framed-bad byte is never loaded; the existing buffer contents and flags are untouched.

## Timing
- **Reset values:** state IDLE, `enable_timer`=0, `rx_data`=8'hFF, `data_ready`=0, `overrun_error`=0, `framing_error`=0, sr=9'h1FF.
- **Start latency:** the falling edge on `serial_in` reaches `start_edge` 2 cycles later (synchronizer). START follows 1 cycle later, and `enable_timer` rises 1 cycle after that (RECEIVE).
- **Frame completion:** `packet_done` is sampled high at cycle N. Then:
  - STOP_CHK at N+1.
  - `framing_error` is valid at N+2; STORE is at N+2.
  - `rx_data`/`data_ready` are valid at N+3.
- **`enable_timer` deassert:** low from N+1 onward.
- **`data_read` latency:** clears flags on the edge following the sampled cycle.
- **Reset mid-frame:** asynchronous return to reset values, and the partial byte is discarded.
- **Line glitch after start:** a low-then-high blip still starts a frame. A stop bit sampled 0 yields a framing error and no load.

## Test plan
- **Reset:** assert `n_rst`=0 mid-RECEIVE -> all outputs at reset values immediately; `enable_timer`=0.
- **Good frame:** send 0xA5 (bits 1,0,1,0,0,1,0,1, stop 1) with 10-cycle bit period and the timer model -> `rx_data`=8'hA5, `data_ready`=1 at packet_done+3, `framing_error`=0.
- **Bad stop bit:** send 0x3C with stop bit 0 -> `framing_error`=1 at packet_done+2, `data_ready` unchanged, `rx_data` still holds the prior byte. The next good frame clears `framing_error` at its START.
- **Overrun:** send 0x11 then 0x22 without `data_read` -> `rx_data`=8'h22, `data_ready`=1, `overrun_error`=1. Then pulse `data_read` -> both flags 0.
- **Read/load collision:** `data_read` high in the same cycle as `load` of 0x7E -> `data_ready`=1, `overrun_error`=0, `rx_data`=8'h7E.
- **Ignored events:** falling edge during RECEIVE and stray `packet_done` in IDLE -> no state change, no extra load, `enable_timer` unaffected.
